alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 166 ++++++++++++++++
 tb/tb_alu_core.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core : two-stage pipelined 8-bit ALU with a 9-bit result.
//
// Stage 1 registers the operands and the opcode, and marks the slot valid.
// Stage 2 evaluates the registered op and registers the result and the flags.
// Latency is two enabled clock edges. Throughput is one op per enabled cycle.
//
// Ports
//   clk        in   single clock; all state updates on its rising edge
//   rst        in   synchronous, active-high reset (wins over ce)
//   OPA, OPB   in   8-bit operands
//   cin        in   carry/borrow-in for ADD_CIN / SUB_CIN
//   ce         in   clock enable; 0 freezes both pipeline stages
//   mode       in   1 = arithmetic opcode set, 0 = logical opcode set
//   cmd        in   4-bit opcode
//   res        out  9-bit registered result
//   oflow      out  borrow flag of the subtract family
//   cout       out  carry flag of the add family
//   g, e, l    out  CMP outcome (greater / equal / less), unsigned
//   err        out  illegal opcode or illegal rotate amount
// ---------------------------------------------------------------------------
module alu_core (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] OPA,
   input  logic [7:0] OPB,
   input  logic       cin,
   input  logic       ce,
   input  logic       mode,
   input  logic [3:0] cmd,
   output logic [8:0] res,
   output logic       oflow,
   output logic       cout,
   output logic       g,
   output logic       e,
   output logic       l,
   output logic       err
);

   // stage 1 registers
   logic [7:0] a_q, b_q;
   logic       cin_q, mode_q, vld_q;
   logic [3:0] cmd_q;

   // stage 2 registers (module outputs)
   logic [8:0] res_q;
   logic       oflow_q, cout_q, g_q, e_q, l_q, err_q;

   // stage 2 next-state values
   logic [8:0]  res_d;
   logic        oflow_d, cout_d, g_d, e_d, l_d, err_d;
   logic [8:0]  a9_s, b9_s, cin9_s;
   logic [15:0] rot_s;

   assign a9_s   = {1'b0, a_q};
   assign b9_s   = {1'b0, b_q};
   assign cin9_s = {8'd0, cin_q};

   // Stage 2 datapath: evaluate the op held in stage 1.
   always_comb begin
      res_d   = 9'd0;
      oflow_d = 1'b0;
      cout_d  = 1'b0;
      g_d     = 1'b0;
      e_d     = 1'b0;
      l_d     = 1'b0;
      err_d   = 1'b0;
      rot_s   = 16'd0;
      if (mode_q) begin
         case (cmd_q)
            4'd0: begin res_d = a9_s + b9_s;          cout_d = res_d[8]; end
            4'd1: begin res_d = a9_s - b9_s;          oflow_d = (a9_s < b9_s); end
            4'd2: begin res_d = a9_s + b9_s + cin9_s; cout_d = res_d[8]; end
            4'd3: begin res_d = a9_s - b9_s - cin9_s; oflow_d = (a9_s < (b9_s + cin9_s)); end
            4'd4: begin res_d = a9_s + 9'd1;          cout_d = res_d[8]; end
            4'd5: begin res_d = a9_s - 9'd1;          oflow_d = (a_q == 8'd0); end
            4'd6: begin res_d = b9_s + 9'd1;          cout_d = res_d[8]; end
            4'd7: begin res_d = b9_s - 9'd1;          oflow_d = (b_q == 8'd0); end
            4'd8: begin
               g_d = (a_q > b_q);
               e_d = (a_q == b_q);
               l_d = (a_q < b_q);
            end
            default: err_d = 1'b1;
         endcase
      end else begin
         case (cmd_q)
            4'd0:  res_d = {1'b0, a_q & b_q};
            4'd1:  res_d = {1'b0, ~(a_q & b_q)};
            4'd2:  res_d = {1'b0, a_q | b_q};
            4'd3:  res_d = {1'b0, ~(a_q | b_q)};
            4'd4:  res_d = {1'b0, a_q ^ b_q};
            4'd5:  res_d = {1'b0, ~(a_q ^ b_q)};
            4'd6:  res_d = {1'b0, ~a_q};
            4'd7:  res_d = {1'b0, ~b_q};
            4'd8:  res_d = {2'b00, a_q[7:1]};
            4'd9:  res_d = {2'b00, b_q[7:1]};
            4'd10: res_d = {1'b0, a_q[6:0], 1'b0};
            4'd11: res_d = {1'b0, b_q[6:0], 1'b0};
            // Rotates work on {A,A}: the window upper byte after a left
            // shift, or the lower byte after a right shift, is the rotation.
            4'd12: begin
               if (b_q[7:4] != 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  rot_s = {a_q, a_q} << b_q[2:0];
                  res_d = {1'b0, rot_s[15:8]};
               end
            end
            4'd13: begin
               if (b_q[7:4] != 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  rot_s = {a_q, a_q} >> b_q[2:0];
                  res_d = {1'b0, rot_s[7:0]};
               end
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   // Pipeline registers: reset dominates ce; an empty stage 1 leaves outputs untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= 8'd0;
         b_q     <= 8'd0;
         cin_q   <= 1'b0;
         mode_q  <= 1'b0;
         cmd_q   <= 4'd0;
         vld_q   <= 1'b0;
         res_q   <= 9'd0;
         oflow_q <= 1'b0;
         cout_q  <= 1'b0;
         g_q     <= 1'b0;
         e_q     <= 1'b0;
         l_q     <= 1'b0;
         err_q   <= 1'b0;
      end else if (ce) begin
         a_q    <= OPA;
         b_q    <= OPB;
         cin_q  <= cin;
         mode_q <= mode;
         cmd_q  <= cmd;
         vld_q  <= 1'b1;
         if (vld_q) begin
            res_q   <= res_d;
            oflow_q <= oflow_d;
            cout_q  <= cout_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            err_q   <= err_d;
         end
      end
   end

   assign res   = res_q;
   assign oflow = oflow_q;
   assign cout  = cout_q;
   assign g     = g_q;
   assign e     = e_q;
   assign l     = l_q;
   assign err   = err_q;

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core : directed self-checking bench for alu_core.
// Ops are streamed one per cycle. Each check after a tick covers the op that
// was issued one step earlier, because that op has just left stage 2.
// Flag vectors are written as {oflow, cout, g, e, l, err}.
// ---------------------------------------------------------------------------
module tb_alu_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] OPA = 8'd0;
   logic [7:0] OPB = 8'd0;
   logic       cin = 1'b0;
   logic       ce = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] cmd = 4'd0;
   logic [8:0] res;
   logic       oflow, cout, g, e, l, err;

   int passed = 0;
   int total  = 0;

   localparam logic [5:0] F_NONE = 6'b000000;
   localparam logic [5:0] F_OFL  = 6'b100000;
   localparam logic [5:0] F_COUT = 6'b010000;
   localparam logic [5:0] F_G    = 6'b001000;
   localparam logic [5:0] F_E    = 6'b000100;
   localparam logic [5:0] F_L    = 6'b000010;
   localparam logic [5:0] F_ERR  = 6'b000001;

   alu_core dut (
      .clk(clk), .rst(rst), .OPA(OPA), .OPB(OPB), .cin(cin), .ce(ce),
      .mode(mode), .cmd(cmd), .res(res), .oflow(oflow), .cout(cout),
      .g(g), .e(e), .l(l), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic m, input logic [3:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
      mode = m;
      cmd  = c;
      OPA  = a;
      OPB  = b;
      cin  = ci;
   endtask

   task automatic chk(input string tag, input logic [8:0] exp_res, input logic [5:0] exp_flags);
      logic [14:0] obs;
      logic [14:0] expv;
      obs  = {res, oflow, cout, g, e, l, err};
      expv = {exp_res, exp_flags};
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed res=%h flags=%b, expected res=%h flags=%b",
                  tag, obs[14:6], obs[5:0], exp_res, exp_flags);
   endtask

   initial begin
      // reset held with ce low
      tick();
      tick();
      chk("reset_state", 9'h000, F_NONE);

      rst = 1'b0;
      ce  = 1'b1;
      issue(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);  tick(); chk("post_reset_zero", 9'h000, F_NONE);
      issue(1'b1, 4'd1, 8'h05, 8'h07, 1'b0);  tick(); chk("add_ff_01", 9'h100, F_COUT);
      issue(1'b1, 4'd8, 8'h3C, 8'h3C, 1'b0);  tick(); chk("sub_05_07", 9'h1FE, F_OFL);
      issue(1'b1, 4'd2, 8'hFF, 8'h00, 1'b1);  tick(); chk("cmp_eq", 9'h000, F_E);
      issue(1'b1, 4'd3, 8'h10, 8'h10, 1'b1);  tick(); chk("add_cin", 9'h100, F_COUT);
      issue(1'b1, 4'd4, 8'hFF, 8'h00, 1'b0);  tick(); chk("sub_cin", 9'h1FF, F_OFL);
      issue(1'b1, 4'd5, 8'h00, 8'h00, 1'b0);  tick(); chk("inc_a", 9'h100, F_COUT);
      issue(1'b1, 4'd6, 8'h00, 8'h7F, 1'b0);  tick(); chk("dec_a_zero", 9'h1FF, F_OFL);
      issue(1'b1, 4'd7, 8'h00, 8'h05, 1'b0);  tick(); chk("inc_b", 9'h080, F_NONE);
      issue(1'b1, 4'd8, 8'h80, 8'h7F, 1'b0);  tick(); chk("dec_b", 9'h004, F_NONE);
      issue(1'b1, 4'd8, 8'h01, 8'h02, 1'b0);  tick(); chk("cmp_gt", 9'h000, F_G);
      issue(1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0);  tick(); chk("cmp_lt", 9'h000, F_L);
      issue(1'b0, 4'd1, 8'hF0, 8'h3C, 1'b0);  tick(); chk("and", 9'h030, F_NONE);
      issue(1'b0, 4'd2, 8'hF0, 8'h0F, 1'b0);  tick(); chk("nand", 9'h0CF, F_NONE);
      issue(1'b0, 4'd3, 8'hF0, 8'h0F, 1'b0);  tick(); chk("or", 9'h0FF, F_NONE);
      issue(1'b0, 4'd4, 8'hAA, 8'h0F, 1'b0);  tick(); chk("nor", 9'h000, F_NONE);
      issue(1'b0, 4'd5, 8'hAA, 8'h0F, 1'b0);  tick(); chk("xor", 9'h0A5, F_NONE);
      issue(1'b0, 4'd6, 8'h0F, 8'h00, 1'b0);  tick(); chk("xnor", 9'h05A, F_NONE);
      issue(1'b0, 4'd7, 8'h00, 8'h01, 1'b0);  tick(); chk("not_a", 9'h0F0, F_NONE);
      issue(1'b0, 4'd8, 8'h81, 8'h00, 1'b0);  tick(); chk("not_b", 9'h0FE, F_NONE);
      issue(1'b0, 4'd9, 8'h00, 8'h03, 1'b0);  tick(); chk("shr1_a", 9'h040, F_NONE);
      issue(1'b0, 4'd10, 8'h81, 8'h00, 1'b0); tick(); chk("shr1_b", 9'h001, F_NONE);
      issue(1'b0, 4'd11, 8'h00, 8'hC0, 1'b0); tick(); chk("shl1_a", 9'h002, F_NONE);
      issue(1'b0, 4'd12, 8'h81, 8'h01, 1'b0); tick(); chk("shl1_b", 9'h080, F_NONE);
      issue(1'b0, 4'd12, 8'h81, 8'h11, 1'b0); tick(); chk("rol_81_1", 9'h003, F_NONE);
      issue(1'b0, 4'd13, 8'h81, 8'h02, 1'b0); tick(); chk("rol_bad_amount", 9'h000, F_ERR);
      issue(1'b0, 4'd13, 8'h81, 8'h80, 1'b0); tick(); chk("ror_81_2", 9'h060, F_NONE);
      issue(1'b1, 4'd9, 8'hFF, 8'hFF, 1'b1);  tick(); chk("ror_bad_amount", 9'h000, F_ERR);

      // illegal-opcode stream, one per cycle
      for (int c = 10; c <= 15; c++) begin
         issue(1'b1, 4'(c), 8'hFF, 8'hFF, 1'b1);
         tick();
         chk("err_arith", 9'h000, F_ERR);
      end
      issue(1'b0, 4'd14, 8'hFF, 8'h01, 1'b1); tick(); chk("err_arith_15", 9'h000, F_ERR);
      issue(1'b0, 4'd15, 8'hFF, 8'h01, 1'b1); tick(); chk("err_logic_14", 9'h000, F_ERR);
      issue(1'b1, 4'd0, 8'h01, 8'h02, 1'b0);  tick(); chk("err_logic_15", 9'h000, F_ERR);

      // stall: ADD 1+2 is in stage 1; garbage on the inputs must not be captured
      ce = 1'b0;
      issue(1'b1, 4'd1, 8'hF0, 8'h01, 1'b0);
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("stall_hold", 9'h000, F_ERR);
      end
      ce = 1'b1;
      issue(1'b0, 4'd0, 8'hFF, 8'hFF, 1'b0);  tick(); chk("add_after_stall", 9'h003, F_NONE);

      // reset flushes the XOR held in stage 1 and discards the inputs on its edge
      issue(1'b0, 4'd4, 8'hF0, 8'hFF, 1'b0);  tick(); chk("and_ff_ff", 9'h0FF, F_NONE);
      rst = 1'b1;
      issue(1'b1, 4'd0, 8'h01, 8'h01, 1'b0);  tick(); chk("reset_clears", 9'h000, F_NONE);
      rst = 1'b0;
      issue(1'b0, 4'd2, 8'h0F, 8'h30, 1'b0);  tick(); chk("flushed_op_hidden", 9'h000, F_NONE);
      issue(1'b1, 4'd8, 8'h05, 8'h05, 1'b0);  tick(); chk("first_op_after_reset", 9'h03F, F_NONE);
      tick();                                         chk("cmp_after_reset", 9'h000, F_E);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Watchdog: never let the run hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d done", passed, total);
      $fatal(1);
   end

endmodule
